// File: rtl/uart_rx_term.sv
// UART receive terminal: 2-flop synchroniser, centre-sampling frame FSM, sticky
// error flags and a first-word fall-through character FIFO.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | line idle, waiting for a falling edge on the synchronised rx
// S_START | timing to the centre of the start bit, rejecting glitches
// S_DATA  | sampling data bits, LSB first
// S_PARITY| sampling and checking the parity bit
// S_STOP  | sampling stop bit(s); pushes the character if all are high
// S_BREAK | stop bit was low; waiting for the line to return high
module uart_rx_term #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          clr_err,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun_err
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic          ODD_PAR   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    logic rx_meta;
    logic rxs;
    logic rxs_d;
    logic start_edge;

    state_t               state;
    state_t               state_nxt;
    logic [TW-1:0]        timer;
    logic [TW-1:0]        timer_nxt;
    logic [BW-1:0]        bit_cnt;
    logic [BW-1:0]        bit_cnt_nxt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_nxt;
    logic                 stop_cnt;
    logic                 stop_cnt_nxt;
    logic                 tick;
    logic                 push;
    logic                 par_set;
    logic                 frm_set;
    logic                 ovr_set;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wptr;
    logic [PW-1:0]        rptr;
    logic [LW-1:0]        count;
    logic                 pop;
    logic                 wr_ok;

    // rxs_d doubles as the edge-detect history; all three reset to the idle level
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    assign start_edge = rxs_d & ~rxs;
    assign tick       = (timer == '0);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= S_IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            stop_cnt <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shift    <= shift_nxt;
            stop_cnt <= stop_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        timer_nxt    = tick ? timer : timer - 1'b1;
        bit_cnt_nxt  = bit_cnt;
        shift_nxt    = shift;
        stop_cnt_nxt = stop_cnt;
        push         = 1'b0;
        par_set      = 1'b0;
        frm_set      = 1'b0;

        case (state)
            S_IDLE: begin
                timer_nxt = HALF_LOAD;
                if (start_edge) begin
                    state_nxt   = S_START;
                    bit_cnt_nxt = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    timer_nxt = FULL_LOAD;
                    state_nxt = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    timer_nxt = FULL_LOAD;
                    shift_nxt = {rxs, shift[DATA_BITS-1:1]};
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt    = (PARITY != 0) ? S_PARITY : S_STOP;
                        stop_cnt_nxt = 1'b0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    timer_nxt    = FULL_LOAD;
                    state_nxt    = S_STOP;
                    stop_cnt_nxt = 1'b0;
                    // odd wants an overall xor of 1, even wants 0
                    par_set      = (^{shift, rxs}) ^ ODD_PAR;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (!rxs) begin
                        frm_set   = 1'b1;
                        state_nxt = S_BREAK;
                    end else if (stop_cnt == LAST_STOP) begin
                        push      = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        stop_cnt_nxt = 1'b1;
                        timer_nxt    = FULL_LOAD;
                    end
                end
            end
            S_BREAK: begin
                if (rxs) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign rd_valid   = (count != '0);
    assign fifo_full  = (count == LW'(FIFO_DEPTH));
    assign fifo_level = count;
    assign pop        = rd_en & rd_valid;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign wr_ok      = push & (~fifo_full | pop);
    assign ovr_set    = push & fifo_full & ~pop;
    assign rd_data    = rd_valid ? mem[rptr] : '0;

    always_ff @(posedge HCLK) begin
        if (wr_ok) begin
            mem[wptr] <= shift;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            parity_err  <= par_set | (parity_err  & ~clr_err);
            frame_err   <= frm_set | (frame_err   & ~clr_err);
            overrun_err <= ovr_set | (overrun_err & ~clr_err);
        end
    end

endmodule
